// File: rtl/counterupdown_param_1clk_posedge_sync_resetp_pkg.sv
// Shared step encoding for the up/down counter and its next-value calculator.
// The step kind is resolved once from the control strobes so the datapath sees a single selector.
package counterupdown_param_1clk_posedge_sync_resetp_pkg;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2,
      STEP_LOAD = 2'd3
   } step_e;

   // Load beats enable; direction only matters while enabled.
   function automatic step_e decode_step(input logic load, input logic enable, input logic up);
      step_e s;
      if (load) begin
         s = STEP_LOAD;
      end else if (enable) begin
         s = up ? STEP_UP : STEP_DOWN;
      end else begin
         s = STEP_HOLD;
      end
      return s;
   endfunction

endpackage

// File: rtl/counterupdown_param_1clk_posedge_sync_resetp_next.sv
// Purely combinational next-count calculator for a [0 .. limit] up/down counter.
// Reusable by multi-channel counter banks; o_wrap marks a wrap or a first saturation hit.
module counter_next_value
   import counterupdown_param_1clk_posedge_sync_resetp_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SATURATE = 0
) (
   input  step_e             i_step,
   input  logic [WIDTH-1:0]  i_count,
   input  logic [WIDTH-1:0]  i_limit,
   input  logic [WIDTH-1:0]  i_load_value,
   output logic [WIDTH-1:0]  o_next,
   output logic              o_wrap
);

   localparam bit SAT = (SATURATE != 0);

   logic [WIDTH-1:0] w_inc;
   logic [WIDTH-1:0] w_dec;

   assign w_inc = i_count + 1'b1;
   assign w_dec = i_count - 1'b1;

   always_comb begin
      o_next = i_count;
      o_wrap = 1'b0;
      unique case (i_step)
         STEP_LOAD: begin
            o_next = i_load_value;
         end
         STEP_UP: begin
            if (i_count < i_limit) begin
               o_next = w_inc;
               o_wrap = SAT && (w_inc == i_limit);
            end else if (SAT) begin
               o_next = i_limit;
            end else begin
               o_next = '0;
               o_wrap = 1'b1;
            end
         end
         STEP_DOWN: begin
            // Out-of-range loaded values are pulled back into range without a wrap.
            if (i_count > i_limit) begin
               o_next = i_limit;
            end else if (i_count != '0) begin
               o_next = w_dec;
               o_wrap = SAT && (w_dec == '0);
            end else if (!SAT) begin
               o_next = i_limit;
               o_wrap = 1'b1;
            end
         end
         default: begin
            o_next = i_count;
         end
      endcase
   end

endmodule

// File: rtl/counterupdown_param_1clk_posedge_sync_resetp.sv
// Parametrised up/down counter with load, enable, programmable upper limit and wrap/saturate ends.
// Boundary flags and the wrap pulse are registered alongside the count.
module counterupdown_param_1clk_posedge_sync_resetp
   import counterupdown_param_1clk_posedge_sync_resetp_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '1,
   parameter int               SATURATE    = 0
) (
   input  logic              clock0,
   input  logic              reset,
   input  logic              enable,
   input  logic              up,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic [WIDTH-1:0]  limit,
   output logic [WIDTH-1:0]  count,
   output logic              at_zero,
   output logic              at_limit,
   output logic              wrap
);

   logic [WIDTH-1:0] r_count    = RESET_VALUE;
   logic             r_at_zero  = (RESET_VALUE == '0);
   logic             r_at_limit = 1'b0;
   logic             r_wrap     = 1'b0;

   step_e            w_step;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;

   assign w_step = decode_step(load, enable, up);

   counter_next_value #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_next (
      .i_step       (w_step),
      .i_count      (r_count),
      .i_limit      (limit),
      .i_load_value (load_value),
      .o_next       (w_next),
      .o_wrap       (w_wrap)
   );

   // Flags are evaluated on the next count against the limit seen this cycle.
   always_ff @(posedge clock0) begin
      if (reset) begin
         r_count    <= RESET_VALUE;
         r_at_zero  <= (RESET_VALUE == '0);
         r_at_limit <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_count    <= w_next;
         r_at_zero  <= (w_next == '0);
         r_at_limit <= (w_next == limit);
         r_wrap     <= w_wrap;
      end
   end

   assign count    = r_count;
   assign at_zero  = r_at_zero;
   assign at_limit = r_at_limit;
   assign wrap     = r_wrap;

endmodule
